// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename/wakeup types and widths
//
// Purpose: widths and the wakeup lane record shared by Rename, the
//          reservation station, the ROB and the wakeup broadcast arbiter.
// Ports:   none (package).
package rename_pkg;

  localparam int TAG_W            = 6;
  localparam int VALUE_W          = 32;
  localparam int NUM_WAKEUP_PORTS = 4;

  typedef struct packed {
    logic               active;
    logic [TAG_W-1:0]   tag;
    logic [VALUE_W-1:0] value;
  } wakeup_t;

endpackage

// File: rtl/rr_multi_grant.sv
// rtl/rr_multi_grant.sv - combinational round-robin multi-grant scanner
//
// Purpose: scans requesters starting at rr_ptr and grants up to NUM_PORTS of
//          them; the k-th grant in scan order is assigned lane k.
// Ports:
//   valid      in  NUM_REQ          requesters that need a lane
//   rr_ptr     in  clog2(NUM_REQ)   first requester visited this cycle
//   grant      out NUM_REQ          per-requester grant
//   lane_valid out NUM_PORTS        lane k carries a grant
//   lane_idx   out NUM_PORTS x idx  requester index on lane k
//   any_grant  out 1                at least one grant issued
//   next_ptr   out clog2(NUM_REQ)   last granted index + 1, wrapped
module rr_multi_grant #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_REQ-1:0]                           valid,
  input  logic [$clog2(NUM_REQ)-1:0]                   rr_ptr,
  output logic [NUM_REQ-1:0]                           grant,
  output logic [NUM_PORTS-1:0]                         lane_valid,
  output logic [NUM_PORTS-1:0][$clog2(NUM_REQ)-1:0]    lane_idx,
  output logic                                         any_grant,
  output logic [$clog2(NUM_REQ)-1:0]                   next_ptr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic [PW-1:0]    cnt;
  logic             full;

  always_comb begin
    grant      = '0;
    lane_valid = '0;
    lane_idx   = '0;
    any_grant  = 1'b0;
    next_ptr   = rr_ptr;
    sum        = '0;
    idx        = '0;
    cnt        = '0;
    full       = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit so rr_ptr + off cannot overflow before the wrap compare.
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (valid[idx] && !full) begin
        grant[idx]      = 1'b1;
        lane_valid[cnt] = 1'b1;
        lane_idx[cnt]   = idx;
        any_grant       = 1'b1;
        next_ptr        = (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
        if (cnt == PW'(NUM_PORTS-1)) begin
          full = 1'b1;
        end else begin
          cnt = cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wakeup_broadcast_arbiter.sv
// rtl/wakeup_broadcast_arbiter.sv - shares 4 wakeup lanes among FU producers
//
// Purpose: round-robin grants up to 4 pending results per cycle onto
//          registered wakeup lanes. Tag-0 results are accepted and dropped.
//          Optional macro WAKEUP_ARB_STARVE_CHECK_EN adds per-requester
//          wait counters that stop simulation when a requester starves.
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   req_valid  in  NUM_REQ     result pending, held until accepted
//   req_tag    in  NUM_REQ*6   tag of requester i in [6i+5:6i]
//   req_value  in  NUM_REQ*32  value of requester i in [32i+31:32i]
//   req_ready  out NUM_REQ     combinational accept
//   wakeup_k_active/tag/value  registered lane k (k = 0..3)
module wakeup_broadcast_arbiter
  import rename_pkg::*;
#(
  parameter int NUM_REQ   = 6,
  parameter int NUM_PORTS = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*VALUE_W-1:0] req_value,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       wakeup_0_active,
  output logic [TAG_W-1:0]           wakeup_0_tag,
  output logic [VALUE_W-1:0]         wakeup_0_value,
  output logic                       wakeup_1_active,
  output logic [TAG_W-1:0]           wakeup_1_tag,
  output logic [VALUE_W-1:0]         wakeup_1_value,
  output logic                       wakeup_2_active,
  output logic [TAG_W-1:0]           wakeup_2_tag,
  output logic [VALUE_W-1:0]         wakeup_2_value,
  output logic                       wakeup_3_active,
  output logic [TAG_W-1:0]           wakeup_3_tag,
  output logic [VALUE_W-1:0]         wakeup_3_value
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 4 || NUM_REQ > 16 || NUM_PORTS != NUM_WAKEUP_PORTS || MAX_WAIT < 1) begin : g_bad_params
    $error("wakeup_broadcast_arbiter: illegal parameters");
  end

  logic [NUM_REQ-1:0]                tag_nz;
  logic [NUM_REQ-1:0]                lane_req;
  logic [NUM_REQ-1:0]                zero_req;
  logic [NUM_REQ-1:0]                grant;
  logic [NUM_PORTS-1:0]              lane_valid;
  logic [NUM_PORTS-1:0][IDX_W-1:0]   lane_idx;
  logic                              any_grant;
  logic [IDX_W-1:0]                  next_ptr;
  logic [IDX_W-1:0]                  rr_ptr;
  wakeup_t [NUM_PORTS-1:0]           lane_q;

  always_comb begin
    tag_nz = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_nz[i] = |req_tag[i*TAG_W +: TAG_W];
    end
  end

  // Physical register 0 is never woken, so tag-0 results need no lane.
  assign lane_req = req_valid & tag_nz;
  assign zero_req = req_valid & ~tag_nz;

  rr_multi_grant #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS)
  ) u_grant (
    .valid      (lane_req),
    .rr_ptr     (rr_ptr),
    .grant      (grant),
    .lane_valid (lane_valid),
    .lane_idx   (lane_idx),
    .any_grant  (any_grant),
    .next_ptr   (next_ptr)
  );

  assign req_ready = reset ? '0 : (grant | zero_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      rr_ptr <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        lane_q[k].active <= lane_valid[k];
        if (lane_valid[k]) begin
          lane_q[k].tag   <= req_tag[lane_idx[k]*TAG_W +: TAG_W];
          lane_q[k].value <= req_value[lane_idx[k]*VALUE_W +: VALUE_W];
        end
      end
      if (any_grant) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  assign wakeup_0_active = lane_q[0].active;
  assign wakeup_0_tag    = lane_q[0].tag;
  assign wakeup_0_value  = lane_q[0].value;
  assign wakeup_1_active = lane_q[1].active;
  assign wakeup_1_tag    = lane_q[1].tag;
  assign wakeup_1_value  = lane_q[1].value;
  assign wakeup_2_active = lane_q[2].active;
  assign wakeup_2_tag    = lane_q[2].tag;
  assign wakeup_2_value  = lane_q[2].value;
  assign wakeup_3_active = lane_q[3].active;
  assign wakeup_3_tag    = lane_q[3].tag;
  assign wakeup_3_value  = lane_q[3].value;

  // Downstream CAMs assume unique tags per cycle; there is no recovery.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = i + 1; j < NUM_REQ; j++) begin
          if (lane_req[i] && lane_req[j] &&
              req_tag[i*TAG_W +: TAG_W] == req_tag[j*TAG_W +: TAG_W]) begin
            $fatal(1, "duplicate wakeup tag");
          end
        end
      end
    end
  end

`ifdef WAKEUP_ARB_STARVE_CHECK_EN
  localparam int WAIT_W = $clog2(MAX_WAIT+1);

  logic [NUM_REQ-1:0][WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (req_valid[i]) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (wait_cnt[i] == WAIT_W'(MAX_WAIT)) begin
          $fatal(1, "wakeup requester %0d starved", i);
        end
      end
    end
  end
`endif

endmodule

// File: doc/wakeup_broadcast_arbiter.md
Name: wakeup_broadcast_arbiter

Overview:
- Shares the 4 wakeup broadcast lanes (wakeup_0..3 active/tag/value) among NUM_REQ functional-unit result producers.
- Each cycle, round-robin grants up to 4 pending results and drives them onto registered broadcast lanes.
- Sits between the FUs and the consumers of wakeups: Rename, the reservation station and the ROB.
- Guarantees the "no two wakeups with the same tag" and "no starvation" properties that downstream blocks rely on.

Parameters:
- NUM_REQ, 6, number of result producers (2 ALU, MUL, DIV, LOAD, BRANCH); legal range 4..16.
- NUM_PORTS, 4, number of broadcast lanes; fixed at 4 to match the wakeup bus.
- MAX_WAIT, 8, starvation bound in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  requester i has a result pending; must be held until accepted
- req_tag  input  NUM_REQ*6  physical destination tag of requester i, in bits [6i+5:6i]
- req_value  input  NUM_REQ*32  result value of requester i, in bits [32i+31:32i]
- req_ready  output  NUM_REQ  combinational; a transfer happens when req_valid[i] && req_ready[i]
- wakeup_0_active .. wakeup_3_active  output  1 each  registered lane-valid
- wakeup_0_tag .. wakeup_3_tag  output  6 each  registered lane tag
- wakeup_0_value .. wakeup_3_value  output  32 each  registered lane value

Behaviour:
- Reset: all wakeup_k_active=0, all tags=0, all values=0, rr_ptr=0.
- During reset, req_ready is 0 for every requester.
- Grant scan (combinational): visit requesters in order rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - A valid requester with tag 0 gets req_ready=1 and consumes no lane. Its result is dropped, because p0 is never woken.
  - A valid requester with a nonzero tag is granted if fewer than NUM_PORTS lanes are already assigned this cycle.
  - The k-th granted requester in scan order takes lane k (k=0..3). Ungranted requesters get req_ready=0.
- req_ready depends only on req_valid, req_tag and rr_ptr. Requesters must not make req_valid depend on req_ready.
- Latency: accepted at rising edge N; lane k shows active=1 with that tag and value for exactly the cycle after edge N.
- Unassigned lanes: active=0 next cycle. Tag and value hold their previous contents (don't-care).
- rr_ptr update:
  - If at least one nonzero-tag grant occurred: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Wrap-around uses explicit compare-and-reset, not power-of-two masking.
- Fairness: with all NUM_REQ requesters continuously valid, each requester is granted at least once every ceil(NUM_REQ/NUM_PORTS) cycles.
- Duplicate tags: two simultaneously valid requesters with the same nonzero tag is a protocol error. Simulation $fatal with "duplicate wakeup tag". No hardware recovery.
- No backpressure from downstream: lanes are always consumed.
- Reset mid-operation: results accepted on the edge coincident with reset assertion are discarded. Requesters re-present after reset.

Optional Feature:
- Macro: WAKEUP_ARB_STARVE_CHECK_EN.
- When defined:
  - Per-requester wait counter ($clog2(MAX_WAIT+1) bits) increments every cycle the requester has req_valid && !req_ready.
  - The counter clears on acceptance or on reset.
  - Reaching MAX_WAIT triggers $fatal with "wakeup requester <i> starved".
- When undefined: counters and check are absent; ports and timing are identical.

Decomposition:
- Shared package rename_pkg holds:
  - TAG_W=6, VALUE_W=32, NUM_WAKEUP_PORTS=4.
  - A wakeup_t struct {active, tag, value}, used by Rename, the reservation station and the ROB.
- One natural sub-module, rr_multi_grant: given valid vector, rr_ptr and port count, returns a per-requester grant vector and a per-lane requester index. It is purely combinational.
- The top level holds rr_ptr, the output lane registers and the optional starvation counters.

Test Plan:
- Reset: assert reset mid-stream with 3 requesters valid -> all wakeup_k_active=0, req_ready=0 during reset. First post-reset grant order starts at requester 0.
- Light load: req_valid=6'b000101, tags 12 and 40, values 0xAAAA0001 and 0x55550002 -> both ready same cycle. Next cycle lane0={1,12,0xAAAA0001}, lane1={1,40,0x55550002}, lanes 2-3 inactive. rr_ptr=3.
- Oversubscription: all 6 valid and held, tags 33..38 -> cycle 1 grants req0-3 on lanes 0-3, rr_ptr=4. Cycle 2 grants req4,5 (newly valid req0,1 fill lanes 2-3). No requester waits more than 2 cycles.
- Tag 0: req2 valid with tag 0 alongside 4 nonzero requesters -> req2 ready immediately. All 4 nonzero requesters still granted on lanes 0-3. No lane carries tag 0.
- Wrap-around: rr_ptr=5, req5 and req1 valid -> lane0=req5, lane1=req1, new rr_ptr=2.
- Starvation check: with WAKEUP_ARB_STARVE_CHECK_EN and a forced broken grant (bench override), a requester valid for 8 unaccepted cycles -> $fatal fires. Without the macro, no fatal.
